// File: rtl/cdc_arith_pkg.sv
// Shared types and helpers for the toggle-handshake receive endpoint.
package cdc_arith_pkg;

    typedef enum logic [1:0] {
        ADD = 2'd0,
        SUB = 2'd1,
        MUL = 2'd2,
        MAC = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

    // Width of the shift-add bit counter for a given operand width.
    function automatic int cnt_width(input int data_w);
        return $clog2(data_w) + 1;
    endfunction

endpackage

// File: rtl/sync_chain.sv
// N-flop single-bit synchroniser; all stages clear to 0 on reset.
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ff <= '0;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/cdc_arith_rx.sv
// Receive endpoint: synchronises req_tgl, captures operands, runs ADD/SUB/MUL/MAC,
// and answers with a one-cycle out_valid strobe and an ack_tgl inversion.
module cdc_arith_rx
    import cdc_arith_pkg::*;
#(
    parameter int DATA_W      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_tgl,
    input  logic [DATA_W-1:0]     in_a,
    input  logic [DATA_W-1:0]     in_b,
    input  logic [1:0]            mode,
    output logic                  ack_tgl,
    output logic                  out_valid,
    output logic [2*DATA_W-1:0]   out
);

    localparam int RW = 2 * DATA_W;
    localparam int CW = cnt_width(DATA_W);

    state_e            state_q, state_d;
    logic              req_s, req_seen, pending;
    logic              capture, finish;
    logic [DATA_W-1:0] a_q, b_q, mplier_q;
    op_e               mode_q;
    logic [RW-1:0]     mcand_q, prod_q, acc_q;
    logic [RW-1:0]     prod_next, acc_next, result;
    logic [CW-1:0]     cnt_q;

    sync_chain #(.STAGES(SYNC_STAGES)) u_req_sync (
        .clk (clk),
        .rst (rst),
        .d   (req_tgl),
        .q   (req_s)
    );

    assign pending = (req_s != req_seen);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // capture: accept a pending request; finish: last EXEC cycle, result is ready
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        finish  = 1'b0;
        case (state_q)
            IDLE: begin
                if (pending) begin
                    capture = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (mode_q == ADD || mode_q == SUB || cnt_q == CW'(DATA_W - 1)) begin
                    finish  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        prod_next = prod_q + (mplier_q[0] ? mcand_q : '0);
        acc_next  = acc_q + prod_next;
        result    = '0;
        case (mode_q)
            ADD:     result = RW'(a_q) + RW'(b_q);
            SUB:     result = RW'(a_q) - RW'(b_q);
            MUL:     result = prod_next;
            MAC:     result = acc_next;
            default: result = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_seen  <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            mode_q    <= ADD;
            mcand_q   <= '0;
            mplier_q  <= '0;
            prod_q    <= '0;
            cnt_q     <= '0;
            acc_q     <= '0;
            out       <= '0;
            ack_tgl   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (capture) begin
                req_seen <= req_s;
                a_q      <= in_a;
                b_q      <= in_b;
                mode_q   <= op_e'(mode);
                mcand_q  <= RW'(in_a);
                mplier_q <= in_b;
                prod_q   <= '0;
                cnt_q    <= '0;
            end else if (state_q == EXEC) begin
                // One multiplier bit per cycle, LSB first.
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                prod_q   <= prod_next;
                cnt_q    <= cnt_q + 1'b1;
            end
            if (finish) begin
                out     <= result;
                ack_tgl <= ~ack_tgl;
                if (mode_q == MAC) begin
                    acc_q <= acc_next;
                end
            end
            out_valid <= finish;
        end
    end

endmodule

// File: tb/tb_cdc_arith_rx.sv
// Self-checking bench for cdc_arith_rx at DATA_W=4, SYNC_STAGES=2.
module tb_cdc_arith_rx;

    localparam int W  = 4;
    localparam int RW = 2 * W;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_tgl = 1'b0;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_b = '0;
    logic [1:0]    mode = 2'd0;
    logic          ack_tgl;
    logic          out_valid;
    logic [RW-1:0] out;

    logic [RW-1:0] exp_q[$];
    logic [RW-1:0] model_acc = '0;
    int            checks = 0;
    int            errors = 0;

    cdc_arith_rx #(.DATA_W(W), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_tgl   (req_tgl),
        .in_a      (in_a),
        .in_b      (in_b),
        .mode      (mode),
        .ack_tgl   (ack_tgl),
        .out_valid (out_valid),
        .out       (out)
    );

    always #5 clk = ~clk;

    // Scoreboard: every result strobe pops one expected value.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result got %02h with nothing expected", out);
            end else begin
                logic [RW-1:0] e;
                e = exp_q.pop_front();
                if (out !== e) begin
                    errors++;
                    $display("FAIL result got %02h want %02h", out, e);
                end
            end
        end
    end

    function automatic logic [RW-1:0] calc(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [1:0] m);
        case (m)
            2'd0:    return RW'(a) + RW'(b);
            2'd1:    return RW'(a) - RW'(b);
            2'd2:    return RW'(a) * RW'(b);
            default: return model_acc + RW'(a) * RW'(b);
        endcase
    endfunction

    task automatic do_txn(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] m,
                          input logic [RW-1:0] exp_out, input int exp_lat, input string name);
        logic prev_ack;
        int   n;
        bit   got;
        exp_q.push_back(exp_out);
        if (m == 2'd3) model_acc = model_acc + RW'(a) * RW'(b);
        prev_ack = ack_tgl;
        @(negedge clk);
        #($urandom_range(1, 4));
        in_a = a;
        in_b = b;
        mode = m;
        req_tgl = ~req_tgl;
        @(posedge clk);
        n = 0;
        got = 0;
        while (!got && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (out_valid) got = 1;
        end
        checks++;
        if (!got || n != exp_lat) begin
            errors++;
            $display("FAIL %s latency got %0d want %0d", name, n, exp_lat);
        end
        checks++;
        if (ack_tgl !== ~prev_ack) begin
            errors++;
            $display("FAIL %s ack_tgl got %b want %b", name, ack_tgl, ~prev_ack);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s strobe_width out_valid got %b want 0", name, out_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (out !== '0 || ack_tgl !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got out=%02h ack=%b valid=%b want 00/0/0", out, ack_tgl, out_valid);
        end
        model_acc = '0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_add_sub();
        do_txn(4'd9, 4'd7, 2'd0, 8'h10, 3, "add_9_7");
        do_txn(4'd3, 4'd5, 2'd1, 8'hFE, 3, "sub_3_5");
        do_txn(4'd5, 4'd3, 2'd1, 8'h02, 3, "sub_5_3");
    endtask

    task automatic test_mul();
        do_txn(4'd15, 4'd15, 2'd2, 8'hE1, 6, "mul_15_15");
        do_txn(4'd0,  4'd9,  2'd2, 8'h00, 6, "mul_0_9");
    endtask

    task automatic test_mac();
        do_txn(4'd3,  4'd4,  2'd3, 8'h0C, 6, "mac_3_4");
        do_txn(4'd5,  4'd6,  2'd3, 8'h2A, 6, "mac_5_6");
        do_txn(4'd15, 4'd15, 2'd3, 8'h0B, 6, "mac_15_15");
        do_txn(4'd1,  4'd1,  2'd0, 8'h02, 3, "add_after_mac");
        do_txn(4'd0,  4'd0,  2'd3, 8'h0B, 6, "mac_acc_hold");
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            logic [W-1:0] a, b;
            logic [1:0]   m;
            a = W'($urandom_range(0, 15));
            b = W'($urandom_range(0, 15));
            m = 2'($urandom_range(0, 3));
            do_txn(a, b, m, calc(a, b, m), (m >= 2'd2) ? 6 : 3, "random");
        end
    endtask

    task automatic test_back_to_back();
        logic prev_ack;
        int   first, second;
        exp_q.push_back(8'hE1);
        exp_q.push_back(8'h0D);
        prev_ack = ack_tgl;
        first = 0;
        second = 0;
        @(negedge clk);
        #($urandom_range(1, 4));
        in_a = 4'd15;
        in_b = 4'd15;
        mode = 2'd2;
        req_tgl = ~req_tgl;
        @(posedge clk);
        for (int n = 1; n <= 14; n++) begin
            @(posedge clk);
            #1;
            if (n == 4) begin
                // Operands are already captured; new ones belong to the second request.
                in_a = 4'd6;
                in_b = 4'd7;
                mode = 2'd0;
                req_tgl = ~req_tgl;
            end
            if (n == 7) begin
                checks++;
                if (ack_tgl !== ~prev_ack) begin
                    errors++;
                    $display("FAIL b2b_first_ack got %b want %b", ack_tgl, ~prev_ack);
                end
            end
            if (out_valid) begin
                if (first == 0) first = n;
                else if (second == 0) second = n;
            end
        end
        checks++;
        if (first != 6 || second != 9) begin
            errors++;
            $display("FAIL b2b_timing got %0d,%0d want 6,9", first, second);
        end
        checks++;
        if (ack_tgl !== prev_ack) begin
            errors++;
            $display("FAIL b2b_ack_twice got %b want %b", ack_tgl, prev_ack);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_mul();
        @(negedge clk);
        #($urandom_range(1, 4));
        in_a = 4'd15;
        in_b = 4'd15;
        mode = 2'd2;
        req_tgl = ~req_tgl;
        @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (out !== '0 || ack_tgl !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_outputs got out=%02h ack=%b valid=%b want 00/0/0", out, ack_tgl, out_valid);
        end
        req_tgl = 1'b0;
        model_acc = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        do_txn(4'd2, 4'd2, 2'd0, 8'h04, 3, "add_after_reset");
        do_txn(4'd1, 4'd1, 2'd3, 8'h01, 6, "mac_after_reset");
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_mul();
        test_mac();
        test_random();
        test_back_to_back();
        test_reset_mid_mul();
        repeat (5) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_expected got %0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
